arith_seq: RTL and testbench

- Initiator side of the arithmetic order handshake. Runs one arithmetic instruction on the arithmetic unit:
  - clears the AU and waits for its local sequencers to settle;
  - fetches two operands through register C into A and B;
  - issues exactly one order pulse and waits for the AU answer.
- Sits between the program unit (start, opcode) and the AU control block (order pulses in, answer pulse out).
- Reports completion, illegal opcode, and no-answer (overflow) back to the program unit.

---
 rtl/arith_seq_pkg.sv | 50 +++++
 rtl/arith_seq_cnt.sv | 34 +++
 rtl/arith_seq.sv | 150 +++++++++++++++
 tb/tb_arith_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared definitions for the arithmetic order sequencer.
//   - opcode encodings accepted from the program unit
//   - one-hot state bit indices and the state enum built from them
//   - default settle / timeout cycle counts
// Optional feature macro used by arith_seq: ARITH_SEQ_WATCHDOG_EN.
package arith_seq_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;

   localparam int DEF_SETTLE_CYCLES  = 64;
   localparam int DEF_TIMEOUT_CYCLES = 96;

   localparam int NUM_STATES = 12;
   localparam int S_IDLE     = 0;
   localparam int S_CLR      = 1;
   localparam int S_SETTLE   = 2;
   localparam int S_REQ1     = 3;
   localparam int S_WAIT1    = 4;
   localparam int S_LOAD_A   = 5;
   localparam int S_REQ2     = 6;
   localparam int S_WAIT2    = 7;
   localparam int S_LOAD_B   = 8;
   localparam int S_ORDER    = 9;
   localparam int S_WAIT_ANS = 10;
   localparam int S_DONE     = 11;

   typedef enum logic [NUM_STATES-1:0] {
      ST_IDLE     = 12'(1 << S_IDLE),
      ST_CLR      = 12'(1 << S_CLR),
      ST_SETTLE   = 12'(1 << S_SETTLE),
      ST_REQ1     = 12'(1 << S_REQ1),
      ST_WAIT1    = 12'(1 << S_WAIT1),
      ST_LOAD_A   = 12'(1 << S_LOAD_A),
      ST_REQ2     = 12'(1 << S_REQ2),
      ST_WAIT2    = 12'(1 << S_WAIT2),
      ST_LOAD_B   = 12'(1 << S_LOAD_B),
      ST_ORDER    = 12'(1 << S_ORDER),
      ST_WAIT_ANS = 12'(1 << S_WAIT_ANS),
      ST_DONE     = 12'(1 << S_DONE)
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return op <= OP_AND;
   endfunction

endpackage

// File: rtl/arith_seq_cnt.sv
// arith_seq_cnt: loadable saturating up-counter with a terminal compare.
// Shared by the settle wait and the answer wait of arith_seq.
// Ports:
//   clk, resetn  clock, synchronous active-low reset (count -> 0)
//   load         clear count to 0 (wins over inc)
//   inc          increment, holding at all-ones instead of wrapping
//   term         terminal value to compare against
//   at_term      count == term
module arith_seq_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic         at_term
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

   assign at_term = (count == term);

endmodule

// File: rtl/arith_seq.sv
// arith_seq: initiator side of the arithmetic order handshake.
// Runs one instruction on the AU: clear A, settle, fetch two operands via
// register C into A and B, issue one order pulse, wait for the AU answer.
// Handshake: every *_to_* pulse is high for exactly one cycle; each pulse
// input (start, operand_ready, au_answer) is acted on only in the state that
// waits for it and is otherwise dropped.
// Optional feature macro ARITH_SEQ_WATCHDOG_EN: when defined, an unanswered
// order times out after TIMEOUT_CYCLES and raises sticky overflow_to_pu;
// when undefined, WAIT_ANS waits forever and overflow_to_pu is tied 0.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   start/opcode/abs_from_pu         instruction request from program unit
//   operand_ready_from_mem           register C loaded
//   au_answer_from_au                AU finished the order
//   fetch_operand_to_mem             operand request pulse
//   clear_a / move_c_to_a / move_c_to_b / order_*_to_au   AU control pulses
//   ctrl_abs_to_au                   latched abs flag
//   busy/done/illegal/overflow_to_pu status back to program unit
module arith_seq
   import arith_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start_from_pu,
   input  logic [2:0] opcode_from_pu,
   input  logic       abs_from_pu,
   input  logic       operand_ready_from_mem,
   input  logic       au_answer_from_au,
   output logic       fetch_operand_to_mem,
   output logic       clear_a_to_au,
   output logic       move_c_to_a_to_au,
   output logic       move_c_to_b_to_au,
   output logic       ctrl_abs_to_au,
   output logic       order_add_to_au,
   output logic       order_sub_to_au,
   output logic       order_mul_to_au,
   output logic       order_div_to_au,
   output logic       order_and_to_au,
   output logic       busy_to_pu,
   output logic       done_to_pu,
   output logic       illegal_to_pu,
   output logic       overflow_to_pu
);

   state_t     state;
   logic [2:0] opcode_q;
   logic       abs_q;
   logic       illegal_q;
`ifdef ARITH_SEQ_WATCHDOG_EN
   logic       overflow_q;
`endif

   logic             cnt_load;
   logic             cnt_inc;
   logic             cnt_at_term;
   logic [CNT_W-1:0] cnt_term_val;

   // One counter serves both waits; the terminal value follows the state.
   assign cnt_load     = state[S_CLR] | state[S_ORDER];
   assign cnt_inc      = state[S_SETTLE] | (state[S_WAIT_ANS] & ~au_answer_from_au);
   assign cnt_term_val = state[S_SETTLE] ? CNT_W'(SETTLE_CYCLES - 1)
                                         : CNT_W'(TIMEOUT_CYCLES - 1);

   arith_seq_cnt #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .resetn  (resetn),
      .load    (cnt_load),
      .inc     (cnt_inc),
      .term    (cnt_term_val),
      .at_term (cnt_at_term)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         opcode_q  <= '0;
         abs_q     <= 1'b0;
         illegal_q <= 1'b0;
`ifdef ARITH_SEQ_WATCHDOG_EN
         overflow_q <= 1'b0;
`endif
      end else begin
         illegal_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start_from_pu) begin
                  if (op_legal(opcode_from_pu)) begin
                     opcode_q <= opcode_from_pu;
                     abs_q    <= abs_from_pu;
`ifdef ARITH_SEQ_WATCHDOG_EN
                     overflow_q <= 1'b0;
`endif
                     state    <= ST_CLR;
                  end else begin
                     illegal_q <= 1'b1;
                  end
               end
            end
            ST_CLR:    state <= ST_SETTLE;
            ST_SETTLE: if (cnt_at_term) state <= ST_REQ1;
            ST_REQ1:   state <= ST_WAIT1;
            ST_WAIT1:  if (operand_ready_from_mem) state <= ST_LOAD_A;
            ST_LOAD_A: state <= ST_REQ2;
            ST_REQ2:   state <= ST_WAIT2;
            ST_WAIT2:  if (operand_ready_from_mem) state <= ST_LOAD_B;
            ST_LOAD_B: state <= ST_ORDER;
            ST_ORDER:  state <= ST_WAIT_ANS;
            ST_WAIT_ANS: begin
               // An answer arriving on the limit cycle still wins.
               if (au_answer_from_au) begin
                  state <= ST_DONE;
               end
`ifdef ARITH_SEQ_WATCHDOG_EN
               else if (cnt_at_term) begin
                  overflow_q <= 1'b1;
                  state      <= ST_IDLE;
               end
`endif
            end
            ST_DONE:   state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   // Moore decode: each pulse is a single one-hot state bit.
   assign clear_a_to_au        = state[S_CLR];
   assign fetch_operand_to_mem = state[S_REQ1] | state[S_REQ2];
   assign move_c_to_a_to_au    = state[S_LOAD_A];
   assign move_c_to_b_to_au    = state[S_LOAD_B];
   assign ctrl_abs_to_au       = abs_q;
   assign order_add_to_au      = state[S_ORDER] & (opcode_q == OP_ADD);
   assign order_sub_to_au      = state[S_ORDER] & (opcode_q == OP_SUB);
   assign order_mul_to_au      = state[S_ORDER] & (opcode_q == OP_MUL);
   assign order_div_to_au      = state[S_ORDER] & (opcode_q == OP_DIV);
   assign order_and_to_au      = state[S_ORDER] & (opcode_q == OP_AND);
   assign busy_to_pu           = ~state[S_IDLE];
   assign done_to_pu           = state[S_DONE];
   assign illegal_to_pu        = illegal_q;
`ifdef ARITH_SEQ_WATCHDOG_EN
   assign overflow_to_pu       = overflow_q;
`else
   assign overflow_to_pu       = 1'b0;
`endif

endmodule

// File: tb/tb_arith_seq.sv
// tb_arith_seq: self-checking bench for arith_seq.
// Events (pulses, overflow edges) are expected as {kind, cycle offset from
// the start sample} in exp_q and compared as the DUT emits them; busy is
// checked every cycle against an expected window. Memory and AU responders
// answer fetches and orders with configurable delays.
module tb_arith_seq;
   import arith_seq_pkg::*;

   localparam int EW = 20;
   localparam logic [3:0] K_CLR      = 4'd1;
   localparam logic [3:0] K_FETCH    = 4'd2;
   localparam logic [3:0] K_MOVA     = 4'd3;
   localparam logic [3:0] K_MOVB     = 4'd4;
   localparam logic [3:0] K_DONE     = 4'd5;
   localparam logic [3:0] K_ILL      = 4'd6;
   localparam logic [3:0] K_OVF_RISE = 4'd7;
   localparam logic [3:0] K_ORD      = 4'd8;
   localparam logic [3:0] K_OVF_FALL = 4'd13;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       start_from_pu = 1'b0;
   logic [2:0] opcode_from_pu = 3'd0;
   logic       abs_from_pu = 1'b0;
   logic       operand_ready_from_mem;
   logic       au_answer_from_au;
   logic       fetch_operand_to_mem, clear_a_to_au, move_c_to_a_to_au, move_c_to_b_to_au;
   logic       ctrl_abs_to_au;
   logic       order_add_to_au, order_sub_to_au, order_mul_to_au, order_div_to_au, order_and_to_au;
   logic       busy_to_pu, done_to_pu, illegal_to_pu, overflow_to_pu;

   logic resp_ready = 1'b0, spur_ready = 1'b0, mem_pend = 1'b0;
   logic resp_ans = 1'b0, spur_ans = 1'b0;
   int   ans_delay = 0, ans_cnt = 0;
   assign operand_ready_from_mem = resp_ready | spur_ready;
   assign au_answer_from_au      = resp_ans | spur_ans;

   arith_seq dut (
      .clk(clk), .resetn(resetn),
      .start_from_pu(start_from_pu), .opcode_from_pu(opcode_from_pu), .abs_from_pu(abs_from_pu),
      .operand_ready_from_mem(operand_ready_from_mem), .au_answer_from_au(au_answer_from_au),
      .fetch_operand_to_mem(fetch_operand_to_mem), .clear_a_to_au(clear_a_to_au),
      .move_c_to_a_to_au(move_c_to_a_to_au), .move_c_to_b_to_au(move_c_to_b_to_au),
      .ctrl_abs_to_au(ctrl_abs_to_au),
      .order_add_to_au(order_add_to_au), .order_sub_to_au(order_sub_to_au),
      .order_mul_to_au(order_mul_to_au), .order_div_to_au(order_div_to_au),
      .order_and_to_au(order_and_to_au),
      .busy_to_pu(busy_to_pu), .done_to_pu(done_to_pu),
      .illegal_to_pu(illegal_to_pu), .overflow_to_pu(overflow_to_pu)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard ----------------
   int checks = 0;
   int failures = 0;
   logic [EW-1:0] exp_q[$];
   int   t0 = 0;
   int   busy_lo = 1, busy_hi = 0;
   logic exp_abs = 1'b0;
   logic ovf_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic got(input logic [3:0] kind);
      logic [EW-1:0] act;
      logic [EW-1:0] exp;
      act = {kind, 16'(cyc - t0)};
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_event: got kind %0d rel %0d, expected none", kind, cyc - t0);
      end else begin
         exp = exp_q.pop_front();
         chk("event{kind,rel}", 32'(act), 32'(exp));
      end
   endtask

   function automatic logic [15:0] all_outs();
      return {fetch_operand_to_mem, clear_a_to_au, move_c_to_a_to_au, move_c_to_b_to_au,
              ctrl_abs_to_au, order_add_to_au, order_sub_to_au, order_mul_to_au,
              order_div_to_au, order_and_to_au, busy_to_pu, done_to_pu,
              illegal_to_pu, overflow_to_pu, 2'b00};
   endfunction

   // Monitor: sample away from the active edge.
   always @(negedge clk) begin
      if (clear_a_to_au)        got(K_CLR);
      if (fetch_operand_to_mem) got(K_FETCH);
      if (move_c_to_a_to_au) begin got(K_MOVA); chk("abs_at_load_a", 32'(ctrl_abs_to_au), 32'(exp_abs)); end
      if (move_c_to_b_to_au) begin got(K_MOVB); chk("abs_at_load_b", 32'(ctrl_abs_to_au), 32'(exp_abs)); end
      if (order_add_to_au)      got(K_ORD + 4'd0);
      if (order_sub_to_au)      got(K_ORD + 4'd1);
      if (order_mul_to_au)      got(K_ORD + 4'd2);
      if (order_div_to_au)      got(K_ORD + 4'd3);
      if (order_and_to_au)      got(K_ORD + 4'd4);
      if (done_to_pu)           got(K_DONE);
      if (illegal_to_pu)        got(K_ILL);
      if (overflow_to_pu && !ovf_prev) got(K_OVF_RISE);
      if (!overflow_to_pu && ovf_prev) got(K_OVF_FALL);
      ovf_prev = overflow_to_pu;
      chk("busy", 32'(busy_to_pu), 32'((cyc >= busy_lo) && (cyc <= busy_hi)));
   end

   // ---------------- responders ----------------
   // Memory: operand_ready during the cycle after each fetch.
   always @(negedge clk) begin
      resp_ready = mem_pend;
      mem_pend   = fetch_operand_to_mem;
   end

   // AU: answer ans_delay cycles after an order (0 = never).
   always @(negedge clk) begin
      resp_ans = 1'b0;
      if (ans_cnt > 0) begin
         ans_cnt--;
         if (ans_cnt == 0) resp_ans = 1'b1;
      end
      if ((order_add_to_au | order_sub_to_au | order_mul_to_au | order_div_to_au | order_and_to_au)
          && ans_delay > 0)
         ans_cnt = ans_delay;
   end

   // ---------------- driver tasks ----------------
   task automatic push_normal(input logic [2:0] op, input int done_rel, input logic with_fall);
      exp_q.push_back({K_CLR, 16'd1});
      if (with_fall) exp_q.push_back({K_OVF_FALL, 16'd1});
      exp_q.push_back({K_FETCH, 16'd66});
      exp_q.push_back({K_MOVA, 16'd68});
      exp_q.push_back({K_FETCH, 16'd69});
      exp_q.push_back({K_MOVB, 16'd71});
      exp_q.push_back({K_ORD + {1'b0, op}, 16'd72});
      if (done_rel != 0) exp_q.push_back({K_DONE, 16'(done_rel)});
   endtask

   // Pulses start for one cycle; opcode/abs are scrambled right after.
   task automatic start_op(input logic [2:0] op, input logic ab, input int ad, input int busy_len);
      @(negedge clk);
      t0 = cyc;
      busy_lo = t0 + 1;
      busy_hi = t0 + busy_len;
      exp_abs = ab;
      ans_delay = ad;
      start_from_pu = 1'b1;
      opcode_from_pu = op;
      abs_from_pu = ab;
      @(negedge clk);
      start_from_pu = 1'b0;
      opcode_from_pu = 3'($urandom_range(0, 7));
      abs_from_pu = 1'($urandom_range(0, 1));
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [2:0] op;
      logic       ab;
      int         ans_delay;
      int         done_rel;
      logic       illegal;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int rel;
      vecs[0] = '{3'd0, 1'b0, 2,  75,  1'b0};  // add happy path
      vecs[1] = '{3'd1, 1'b1, 1,  74,  1'b0};  // sub, abs
      vecs[2] = '{3'd4, 1'b0, 5,  78,  1'b0};  // and
      vecs[3] = '{3'd6, 1'b0, 0,  0,   1'b1};  // illegal
      vecs[4] = '{3'd7, 1'b1, 0,  0,   1'b1};  // illegal
      vecs[5] = '{3'd2, 1'b1, 96, 169, 1'b0};  // mul abs, answer on the limit cycle
      vecs[6] = '{3'd3, 1'b0, 3,  76,  1'b0};  // div answered

      // reset
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'(all_outs()), 32'd0);
      resetn = 1'b1;
      repeat (2) @(negedge clk);

      // table-driven single instructions
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].illegal) begin
            exp_q.push_back({K_ILL, 16'd1});
            start_op(vecs[i].op, vecs[i].ab, 0, 0);
         end else begin
            push_normal(vecs[i].op, vecs[i].done_rel, 1'b0);
            start_op(vecs[i].op, vecs[i].ab, vecs[i].ans_delay, vecs[i].done_rel);
         end
         drain($sformatf("vec%0d", i), 300);
      end

      // spurious answers / operand_ready / start while busy
      push_normal(3'd0, 75, 1'b0);
      start_op(3'd0, 1'b0, 2, 75);
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         rel = cyc - t0;
         spur_ans   = (rel == 2) || (rel == 10) || (rel == 67);
         spur_ready = (rel == 68) || (rel == 20);
         start_from_pu = (rel == 30);
         opcode_from_pu = (rel == 30) ? 3'd2 : opcode_from_pu;
      end
      spur_ans = 1'b0;
      spur_ready = 1'b0;
      start_from_pu = 1'b0;
      drain("spurious", 50);

      // reset during WAIT2
      exp_q.push_back({K_CLR, 16'd1});
      exp_q.push_back({K_FETCH, 16'd66});
      exp_q.push_back({K_MOVA, 16'd68});
      exp_q.push_back({K_FETCH, 16'd69});
      start_op(3'd0, 1'b1, 2, 70);
      while (cyc - t0 < 70) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("reset_mid_wait2_outputs", 32'(all_outs()), 32'd0);
      resetn = 1'b1;
      drain("reset_mid", 5);
      push_normal(3'd0, 75, 1'b0);
      start_op(3'd0, 1'b0, 2, 75);
      drain("after_reset", 300);

`ifdef ARITH_SEQ_WATCHDOG_EN
      // unanswered div: overflow after 96 WAIT_ANS cycles, no done
      push_normal(3'd3, 0, 1'b0);
      exp_q.push_back({K_OVF_RISE, 16'd169});
      start_op(3'd3, 1'b0, 0, 168);
      drain("timeout", 400);
      chk("overflow_sticky", 32'(overflow_to_pu), 32'd1);
      // next accepted start clears overflow
      push_normal(3'd0, 75, 1'b1);
      start_op(3'd0, 1'b0, 2, 75);
      drain("after_timeout", 300);
      chk("overflow_cleared", 32'(overflow_to_pu), 32'd0);
`else
      // unanswered div: waits indefinitely, overflow stays 0, reset exits
      push_normal(3'd3, 0, 1'b0);
      start_op(3'd3, 1'b0, 0, 100000);
      while (cyc - t0 < 250) @(negedge clk);
      chk("hang_busy", 32'(busy_to_pu), 32'd1);
      chk("hang_overflow", 32'(overflow_to_pu), 32'd0);
      resetn = 1'b0;
      busy_hi = cyc;
      @(negedge clk);
      resetn = 1'b1;
      drain("hang", 5);
`endif

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL global_timeout: got still running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
